inst_fetch_unit: RTL and testbench
==================================

Name: inst_fetch_unit

Overview:
- Fetch stage that sits directly upstream of the combinational instruction memory and feeds the decode stage.
- Owns the architectural fetch PC and drives the word address into instruction memory, which returns the instruction in the same cycle.
- Captures each {pc, instruction, fault} tuple into a small FIFO and presents it to decode over a valid/ready handshake.
- Accepts a redirect (branch/jal/jalr target) that flushes all queued fetches and restarts at the new PC.

Parameters:
- RESET_PC, 32'h0000_0000, fetch PC loaded on reset.
- DEPTH, 2, FIFO entries; power of two, minimum 2.
- MEM_WORDS, 64, number of valid instruction words; byte addresses >= MEM_WORDS*4 are out of range.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- redirect_valid  input  1  redirect request; ignores FIFO state.
- redirect_pc  input  32  redirect target byte address.
- imem_pc  output  32  byte address to instruction memory; equals fetch_pc.
- imem_inst  input  32  instruction memory read data; combinational from imem_pc.
- out_valid  output  1  FIFO head valid.
- out_ready  input  1  decode accepts head.
- out_pc  output  32  PC of head entry.
- out_inst  output  32  instruction of head entry.
- out_fault  output  1  head entry was fetched out of range.
- occupancy  output  $clog2(DEPTH)+1  current entry count.

Behaviour:
- Reset (async): fetch_pc=RESET_PC, FIFO empty, occupancy=0, out_valid=0. out_pc, out_inst and out_fault are 0 while empty; storage cleared.
- Data path:
  - imem_pc = fetch_pc at all times.
  - fault = (fetch_pc >= MEM_WORDS*4). A faulting entry stores out_inst = 32'h0000_0013 (nop), not imem_inst.
- Each rising edge, with redirect_valid=0:
  - pop = out_valid & out_ready.
  - push = (occupancy < DEPTH) | pop; a full FIFO may push in the same cycle as a pop.
  - On push: write {fetch_pc, inst, fault} at the tail; fetch_pc += 4, wrapping modulo 2^32.
  - occupancy += push - pop.
- Redirect (priority over push and pop):
  - FIFO pointers and occupancy go to 0.
  - fetch_pc <= {redirect_pc[31:2], 2'b00}; low bits are force-aligned.
  - No push and no pop that cycle, even if out_ready=1; a head shown with out_valid=1 in that cycle is discarded.
- Latency:
  - A redirect at edge N makes the new target visible at out_pc after edge N+1 (fetch at N+1, head valid after N+1).
  - From reset release, the first entry is valid after the first edge.
- Throughput: one instruction per cycle sustained while out_ready=1.
- Stall: with out_ready=0 the FIFO fills to DEPTH, then fetch_pc freezes. Head outputs hold stable while out_valid=1 and out_ready=0.
- Faulting PCs still push and advance; decode decides whether to trap. fetch_pc keeps advancing past the range end and wraps at 2^32.
- Pointers wrap modulo DEPTH. Full and empty are distinguished by occupancy, not pointer equality.
- Reset asserted mid-operation: immediate return to reset state; in-flight entries are lost.

Test Plan:
- Reset release, out_ready=1, memory words 0..3 = A,B,C,D -> on consecutive cycles out_pc=0,4,8,12 with out_inst=A,B,C,D; occupancy never exceeds 1 after steady state.
- out_ready=0 for 5 cycles from reset -> occupancy reaches 2 and holds; out_pc=0 stable; imem_pc frozen at 8. Release ready -> entries 0,4,8 delivered in order with no gaps or duplicates.
- Full FIFO with out_ready=1 in the same cycle -> pop and push together; occupancy stays 2 and fetch_pc advances by 4.
- Redirect to 32'h0000_0023 while FIFO full and out_ready=1 -> no pop that cycle; next cycle occupancy=0; following cycle out_pc=32'h20.
- Redirect to 32'h0000_00FC with MEM_WORDS=64 -> out_pc=0xFC with out_fault=0, then 0x100 with out_fault=1 and out_inst=32'h00000013.
- Assert rst for one cycle while 2 entries are queued -> out_valid=0 and occupancy=0 asynchronously; after release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: fetch stage owning the fetch PC. It queues {pc, inst, fault}
//   entries from a combinational instruction memory and hands them to decode.
// Latency: an entry is visible at the head one edge after it is fetched, and a
//   redirect target appears one edge after the redirect edge.
// Backpressure: out_ready=0 fills the FIFO to DEPTH and then freezes the
//   fetch PC. A full FIFO still pushes in a cycle that also pops.
//
// Ports:
//   clk, rst                    clock, async active-high reset
//   redirect_valid, redirect_pc flush the queue and restart fetch at the target
//   imem_pc, imem_inst          instruction memory address and its same-cycle data
//   out_valid, out_ready        head handshake toward decode
//   out_pc, out_inst, out_fault head entry payload (all zero while empty)
//   occupancy                   current number of queued entries

// ifu_fifo: generic synchronous FIFO with flush and a zero-gated head.
// Latency: a pushed word is visible at the head after the push edge.
// Backpressure: the caller must only push into a full FIFO when it also pops.
module ifu_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_flush,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [W-1:0]             i_dat,
  output logic                     o_vld,
  output logic [W-1:0]             o_dat,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  // Pointers wrap naturally because DEPTH is a power of two. Full and empty
  // are told apart by r_count, never by comparing the two pointers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_flush) begin
      // Stale storage is left in place. The head output is gated by r_count,
      // so nothing stale can reach decode.
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        // When full with a simultaneous pop, this slot is the head being
        // popped. Its old value is consumed before the edge writes it.
        r_mem[r_wr_ptr] <= i_dat;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (i_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_vld   = (r_count != '0);
  assign o_dat   = o_vld ? r_mem[r_rd_ptr] : '0;
  assign o_count = r_count;
  assign o_full  = (r_count == FULL_CNT);

endmodule

module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          DEPTH     = 2,
  parameter int          MEM_WORDS = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     redirect_valid,
  input  logic [31:0]              redirect_pc,
  output logic [31:0]              imem_pc,
  input  logic [31:0]              imem_inst,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_pc,
  output logic [31:0]              out_inst,
  output logic                     out_fault,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int CW = $clog2(DEPTH) + 1;
  // The limit is held at 33 bits so that a memory covering the whole 4 GiB
  // space still compares correctly against a 32-bit PC.
  localparam logic [32:0] MEM_LIMIT = 33'(MEM_WORDS) << 2;
  localparam logic [31:0] NOP_INST  = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        fault;
  } fetch_t;

  logic [31:0]   r_fetch_pc;
  logic          w_fault;
  fetch_t        w_entry;
  fetch_t        w_head;
  logic          w_head_vld;
  logic          w_full;
  logic [CW-1:0] w_count;
  logic          w_xfer;
  logic          w_push;
  logic          w_pop;
  logic [31:0]   w_redirect_tgt;

  // Out-of-range fetches carry a nop so that decode never sees undefined
  // memory contents. The fault flag lets decode decide whether to trap.
  assign w_fault       = ({1'b0, r_fetch_pc} >= MEM_LIMIT);
  assign w_entry.pc    = r_fetch_pc;
  assign w_entry.inst  = w_fault ? NOP_INST : imem_inst;
  assign w_entry.fault = w_fault;

  // A redirect overrides both sides of the queue. The head shown this cycle
  // is discarded even if decode signals ready.
  assign w_xfer = w_head_vld & out_ready;
  assign w_pop  = ~redirect_valid & w_xfer;
  assign w_push = ~redirect_valid & (~w_full | w_xfer);

  // Masking the low bits force-aligns the target to a word boundary.
  assign w_redirect_tgt = redirect_pc & ~32'h0000_0003;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_pc <= RESET_PC;
    end else if (redirect_valid) begin
      r_fetch_pc <= w_redirect_tgt;
    end else if (w_push) begin
      // Wraps modulo 2^32, and keeps advancing past the end of memory.
      r_fetch_pc <= r_fetch_pc + 32'd4;
    end
  end

  ifu_fifo #(
    .W     ($bits(fetch_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_flush (redirect_valid),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_dat   (w_entry),
    .o_vld   (w_head_vld),
    .o_dat   (w_head),
    .o_count (w_count),
    .o_full  (w_full)
  );

  assign imem_pc   = r_fetch_pc;
  assign out_valid = w_head_vld;
  assign out_pc    = w_head.pc;
  assign out_inst  = w_head.inst;
  assign out_fault = w_head.fault;
  assign occupancy = w_count;

endmodule

// File: tb/tb_inst_fetch_unit.sv
module tb_inst_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] imem_pc;
  logic [31:0] imem_inst;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        out_fault;
  logic [1:0]  occupancy;

  logic [31:0] mem [64];

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        fault;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  // Combinational instruction memory. Out-of-range reads return garbage,
  // which the DUT must replace with a nop.
  assign imem_inst = (imem_pc < 32'd256) ? mem[imem_pc[7:2]] : 32'hDEAD_BEEF;

  inst_fetch_unit #(
    .RESET_PC  (32'h0000_0000),
    .DEPTH     (2),
    .MEM_WORDS (64)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_pc        (imem_pc),
    .imem_inst      (imem_inst),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_inst       (out_inst),
    .out_fault      (out_fault),
    .occupancy      (occupancy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_entry(input logic [31:0] pc, input logic [31:0] inst, input logic fault);
    exp_t e;
    e.pc    = pc;
    e.inst  = inst;
    e.fault = fault;
    sb.push_back(e);
  endtask

  // Monitor: every head transfer is compared with the next expected entry.
  // A head shown during a redirect is discarded, so it is not a transfer.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && out_valid && out_ready && !redirect_valid) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected actual=pc %h required=no transfer", out_pc);
      end else begin
        e = sb.pop_front();
        chk("sb_pc", out_pc, e.pc);
        chk("sb_inst", out_inst, e.inst);
        chk("sb_fault", {31'b0, out_fault}, {31'b0, e.fault});
      end
    end
  end

  initial begin : watchdog
    #50000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    mem[0] = 32'hAAAA_0001;
    mem[1] = 32'hBBBB_0002;
    mem[2] = 32'hCCCC_0003;
    mem[3] = 32'hDDDD_0004;
    for (int i = 4; i < 64; i++) mem[i] = 32'h1000_0000 + i;

    rst            = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    out_ready      = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_occ", {30'b0, occupancy}, 32'd0);
    chk("rst_out_pc", out_pc, 32'd0);
    chk("rst_out_inst", out_inst, 32'd0);
    chk("rst_out_fault", {31'b0, out_fault}, 32'd0);
    chk("rst_imem_pc", imem_pc, 32'd0);
    step();
    step();

    // Streaming from reset with decode always ready.
    expect_entry(32'h0, 32'hAAAA_0001, 1'b0);
    expect_entry(32'h4, 32'hBBBB_0002, 1'b0);
    expect_entry(32'h8, 32'hCCCC_0003, 1'b0);
    expect_entry(32'hC, 32'hDDDD_0004, 1'b0);
    rst       = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("t1_occ", {30'b0, occupancy}, 32'd1);
    end
    out_ready = 1'b0;
    chk("t1_fetch_pc", imem_pc, 32'd20);
    chk("t1_drain", sb.size(), 32'd0);

    // Stall from reset, then release.
    rst = 1'b1;
    step();
    expect_entry(32'h0, 32'hAAAA_0001, 1'b0);
    expect_entry(32'h4, 32'hBBBB_0002, 1'b0);
    expect_entry(32'h8, 32'hCCCC_0003, 1'b0);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("t2_hold_pc", out_pc, 32'd0);
    end
    chk("t2_occ_full", {30'b0, occupancy}, 32'd2);
    chk("t2_fetch_frozen", imem_pc, 32'd8);
    chk("t2_valid", {31'b0, out_valid}, 32'd1);
    out_ready = 1'b1;
    step();
    // A full FIFO pushes and pops together.
    chk("t3_occ_pushpop", {30'b0, occupancy}, 32'd2);
    chk("t3_fetch_adv", imem_pc, 32'd12);
    step();
    step();
    out_ready = 1'b0;
    chk("t2_drain", sb.size(), 32'd0);

    // Redirect to an unaligned target while full and ready.
    chk("t4_full_pre", {30'b0, occupancy}, 32'd2);
    expect_entry(32'h20, 32'h1000_0008, 1'b0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0023;
    out_ready      = 1'b1;
    step();
    redirect_valid = 1'b0;
    out_ready      = 1'b0;
    chk("t4_occ_flushed", {30'b0, occupancy}, 32'd0);
    chk("t4_valid_flushed", {31'b0, out_valid}, 32'd0);
    chk("t4_fetch_aligned", imem_pc, 32'h20);
    step();
    chk("t4_head_pc", out_pc, 32'h20);
    chk("t4_occ_one", {30'b0, occupancy}, 32'd1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("t4_drain", sb.size(), 32'd0);

    // Redirect to the last in-range word, then cross the end of memory.
    expect_entry(32'hFC, 32'h1000_003F, 1'b0);
    expect_entry(32'h100, 32'h0000_0013, 1'b1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_00FC;
    step();
    redirect_valid = 1'b0;
    out_ready      = 1'b1;
    step();
    chk("t5_fault_in_range", {31'b0, out_fault}, 32'd0);
    step();
    chk("t5_fault_out_range", {31'b0, out_fault}, 32'd1);
    chk("t5_nop", out_inst, 32'h0000_0013);
    step();
    out_ready = 1'b0;
    chk("t5_drain", sb.size(), 32'd0);

    // PC wraps at 2^32, with an unaligned redirect at the top of the space.
    expect_entry(32'hFFFF_FFFC, 32'h0000_0013, 1'b1);
    expect_entry(32'h0, 32'hAAAA_0001, 1'b0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFE;
    step();
    redirect_valid = 1'b0;
    out_ready      = 1'b1;
    step();
    step();
    step();
    out_ready = 1'b0;
    chk("t5b_fetch_wrapped", imem_pc, 32'h8);
    chk("t5b_drain", sb.size(), 32'd0);

    // Asynchronous reset with a full queue.
    step();
    chk("t6_occ_pre", {30'b0, occupancy}, 32'd2);
    rst = 1'b1;
    #1;
    chk("t6_async_valid", {31'b0, out_valid}, 32'd0);
    chk("t6_async_occ", {30'b0, occupancy}, 32'd0);
    chk("t6_async_out_pc", out_pc, 32'd0);
    chk("t6_async_imem_pc", imem_pc, 32'd0);
    step();
    expect_entry(32'h0, 32'hAAAA_0001, 1'b0);
    rst       = 1'b0;
    out_ready = 1'b1;
    step();
    chk("t6_restart_pc", out_pc, 32'd0);
    step();
    out_ready = 1'b0;
    chk("t6_drain", sb.size(), 32'd0);

    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
